alu_exec_unit: RTL and testbench

Parametrised execute-stage ALU combining the 2-bit main-control ALU-op/funct decode with the datapath. Adds SRA, SLTU and the full M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU). Sits between the register-read stage and writeback. Base ops finish in one registered cycle; multiply/divide run on an iterative shift-add / restoring engine behind a valid/ready handshake that stalls the pipeline.

---
 rtl/alu_pkg.sv | 71 +++++++
 rtl/alu_md_iter.sv | 109 ++++++++++
 rtl/alu_exec_unit.sv | 107 ++++++++++
 tb/tb_alu_exec_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings, internal op set, FSM state codes and the ALU-op/funct decode
// used by the execute-stage ALU.
package alu_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } alu_opcode_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic alu_opcode_t alu_decode(
    input logic [1:0] alu_op,
    input logic [2:0] funct3,
    input logic       funct7_5,
    input logic       funct7_0,
    input logic       op,
    input logic       en_m
  );
    alu_opcode_t d;
    d = OP_ADD;
    case (alu_op)
      ALUOP_SUB: d = OP_SUB;
      ALUOP_FUNCT: begin
        if (op && funct7_0 && en_m) begin
          case (funct3)
            3'b000:  d = OP_MUL;
            3'b001:  d = OP_MULH;
            3'b010:  d = OP_MULHSU;
            3'b011:  d = OP_MULHU;
            3'b100:  d = OP_DIV;
            3'b101:  d = OP_DIVU;
            3'b110:  d = OP_REM;
            default: d = OP_REMU;
          endcase
        end else begin
          case (funct3)
            3'b000:  d = (op && funct7_5) ? OP_SUB : OP_ADD;
            3'b001:  d = OP_SLL;
            3'b010:  d = OP_SLT;
            3'b011:  d = OP_SLTU;
            3'b100:  d = OP_XOR;
            3'b101:  d = funct7_5 ? OP_SRA : OP_SRL;
            3'b110:  d = OP_OR;
            default: d = OP_AND;
          endcase
        end
      end
      default: d = OP_ADD;
    endcase
    return d;
  endfunction

  function automatic logic is_md_op(input alu_opcode_t o);
    logic r;
    case (o)
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: r = 1'b1;
      default:                          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_md_iter.sv
// Iterative multiply/divide datapath: magnitude capture on load, one shift-add or
// restoring-subtract step per cycle, and combinational sign fix / result select.
module alu_md_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  alu_opcode_t       op,
  input  logic [XLEN-1:0]   src_a,
  input  logic [XLEN-1:0]   src_b,
  output logic [XLEN-1:0]   md_result
);

  alu_opcode_t     op_reg;
  logic [XLEN-1:0] hi_reg;
  logic [XLEN-1:0] lo_reg;
  logic [XLEN-1:0] opnd_reg;
  logic            div_mode_reg;
  logic            neg_res_reg;
  logic            neg_rem_reg;

  logic            signed_a, signed_b, is_div;
  logic            neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    is_div   = 1'b0;
    case (op)
      OP_MULH:         begin signed_a = 1'b1; signed_b = 1'b1; end
      OP_MULHSU:       signed_a = 1'b1;
      OP_DIV, OP_REM:  begin signed_a = 1'b1; signed_b = 1'b1; is_div = 1'b1; end
      OP_DIVU, OP_REMU: is_div = 1'b1;
      default:         ;
    endcase
  end

  assign neg_a = signed_a & src_a[XLEN-1];
  assign neg_b = signed_b & src_b[XLEN-1];
  assign mag_a = neg_a ? (~src_a + 1'b1) : src_a;
  assign mag_b = neg_b ? (~src_b + 1'b1) : src_b;

  logic [XLEN:0] mul_sum;
  logic [XLEN:0] div_shift;
  logic [XLEN:0] div_diff;

  assign mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : {(XLEN+1){1'b0}});
  assign div_shift = {hi_reg, lo_reg[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg       <= OP_ADD;
      hi_reg       <= '0;
      lo_reg       <= '0;
      opnd_reg     <= '0;
      div_mode_reg <= 1'b0;
      neg_res_reg  <= 1'b0;
      neg_rem_reg  <= 1'b0;
    end else if (load) begin
      op_reg       <= op;
      hi_reg       <= '0;
      lo_reg       <= is_div ? mag_a : mag_b;
      opnd_reg     <= is_div ? mag_b : mag_a;
      div_mode_reg <= is_div;
      // A zero divisor must yield an all-ones quotient, so never negate it.
      neg_res_reg  <= (neg_a ^ neg_b) & ~(is_div & (src_b == '0));
      neg_rem_reg  <= neg_a;
    end else if (step) begin
      if (div_mode_reg) begin
        if (!div_diff[XLEN]) begin
          hi_reg <= div_diff[XLEN-1:0];
          lo_reg <= {lo_reg[XLEN-2:0], 1'b1};
        end else begin
          hi_reg <= div_shift[XLEN-1:0];
          lo_reg <= {lo_reg[XLEN-2:0], 1'b0};
        end
      end else begin
        hi_reg <= mul_sum[XLEN:1];
        lo_reg <= {mul_sum[0], lo_reg[XLEN-1:1]};
      end
    end
  end

  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;

  assign prod     = {hi_reg, lo_reg};
  assign prod_fix = neg_res_reg ? (~prod + 1'b1) : prod;
  assign quot_fix = neg_res_reg ? (~lo_reg + 1'b1) : lo_reg;
  assign rem_fix  = neg_rem_reg ? (~hi_reg + 1'b1) : hi_reg;

  always_comb begin
    md_result = '0;
    case (op_reg)
      OP_MUL:                      md_result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: md_result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             md_result = quot_fix;
      OP_REM, OP_REMU:             md_result = rem_fix;
      default:                     md_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: decode, single-cycle base ops, and the handshake FSM that
// sequences the iterative multiply/divide engine.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            funct7_0,
  input  logic            op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);

  logic [1:0]      state_reg, state_next;
  logic [CW-1:0]   count_reg;
  logic [XLEN-1:0] result_reg;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] md_result;
  logic [CW-1:0]   shamt;
  alu_opcode_t     dec_op;
  logic            dec_md;
  logic            accept;

  assign dec_op    = alu_decode(alu_op, funct3, funct7_5, funct7_0, op, EN_M);
  assign dec_md    = is_md_op(dec_op);
  assign in_ready  = (state_reg == ST_IDLE) | ((state_reg == ST_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_reg == ST_DONE);
  assign busy      = (state_reg == ST_CALC) | (state_reg == ST_FIX);
  assign result    = result_reg;
  assign shamt     = src_b[CW-1:0];

  always_comb begin
    alu_result = '0;
    case (dec_op)
      OP_ADD:  alu_result = src_a + src_b;
      OP_SUB:  alu_result = src_a - src_b;
      OP_SLL:  alu_result = src_a << shamt;
      OP_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLTU: alu_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      OP_XOR:  alu_result = src_a ^ src_b;
      OP_SRL:  alu_result = src_a >> shamt;
      OP_SRA:  alu_result = $unsigned($signed(src_a) >>> shamt);
      OP_OR:   alu_result = src_a | src_b;
      OP_AND:  alu_result = src_a & src_b;
      default: alu_result = '0;
    endcase
  end

  // Acceptance in DONE behaves exactly like acceptance in IDLE.
  always_comb begin
    state_next = state_reg;
    if (accept) begin
      state_next = dec_md ? ST_CALC : ST_DONE;
    end else begin
      case (state_reg)
        ST_CALC: if (count_reg == '0) state_next = ST_FIX;
        ST_FIX:  state_next = ST_DONE;
        ST_DONE: if (out_ready) state_next = ST_IDLE;
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      count_reg  <= '0;
      result_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        count_reg <= CW'(XLEN - 1);
        if (!dec_md) result_reg <= alu_result;
      end else if ((state_reg == ST_CALC) && (count_reg != '0)) begin
        count_reg <= count_reg - 1'b1;
      end
      if (state_reg == ST_FIX) result_reg <= md_result;
    end
  end

  alu_md_iter #(.XLEN(XLEN)) u_md (
    .clk       (clk),
    .rst       (rst),
    .load      (accept & dec_md),
    .step      (state_reg == ST_CALC),
    .op        (dec_op),
    .src_a     (src_a),
    .src_b     (src_b),
    .md_result (md_result)
  );

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (XLEN=32, EN_M=1): base ops, M ops with latency
// and busy window, handshake back-pressure and reset during an iterative op.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  alu_op = 2'b00;
  logic [2:0]  funct3 = 3'b000;
  logic        funct7_5 = 1'b0;
  logic        funct7_0 = 1'b0;
  logic        op = 1'b0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        busy;

  int tests_run = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32), .EN_M(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct3    (funct3),
    .funct7_5  (funct7_5),
    .funct7_0  (funct7_0),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  // Offer one op for a single edge; returns in cycle 1 after acceptance.
  task automatic issue(input logic [1:0] aop, input logic [2:0] f3, input logic f75,
                       input logic f70, input logic o, input logic [31:0] a,
                       input logic [31:0] b);
    alu_op = aop; funct3 = f3; funct7_5 = f75; funct7_0 = f70; op = o;
    src_a = a; src_b = b; in_valid = 1'b1;
    step_cycle();
    in_valid = 1'b0;
  endtask

  task automatic test_base_vec(input string name, input logic [1:0] aop, input logic [2:0] f3,
                               input logic f75, input logic f70, input logic o,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp);
    issue(aop, f3, f75, f70, o, a, b);
    tests_run++;
    if (out_valid !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s valid: out_valid=%b busy=%b required out_valid=1 busy=0", name, out_valid, busy);
    end
    tests_run++;
    if (result !== exp) begin
      fails++;
      $display("FAIL %s result: got %h required %h", name, result, exp);
    end
    $display("[TB] %s a=%h b=%h -> %h", name, a, b, result);
  endtask

  task automatic test_md_vec(input string name, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp);
    int bad_cycle;
    bad_cycle = 0;
    issue(2'b10, f3, 1'b0, 1'b1, 1'b1, a, b);
    src_a = 32'h5A5A_1234;
    src_b = 32'h0000_0003;
    for (int c = 1; c <= 33; c++) begin
      if ((busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) && bad_cycle == 0)
        bad_cycle = c;
      step_cycle();
    end
    tests_run++;
    if (bad_cycle != 0) begin
      fails++;
      $display("FAIL %s busy window: cycle %0d had busy=0 or out_valid=1 or in_ready=1, required busy=1 cycles 1..33", name, bad_cycle);
    end
    tests_run++;
    if (out_valid !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s latency: cycle 34 out_valid=%b busy=%b required 1/0", name, out_valid, busy);
    end
    tests_run++;
    if (result !== exp) begin
      fails++;
      $display("FAIL %s result: got %h required %h", name, result, exp);
    end
    $display("[TB] %s a=%h b=%h -> %h", name, a, b, result);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step_cycle();
    rst = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
      fails++;
      $display("FAIL reset state: out_valid=%b busy=%b in_ready=%b result=%h required 0/0/1/0",
               out_valid, busy, in_ready, result);
    end
    $display("[TB] reset out_valid=%b busy=%b in_ready=%b result=%h", out_valid, busy, in_ready, result);
  endtask

  task automatic test_shift();
    test_base_vec("sra", 2'b10, 3'b101, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'd4, 32'hF800_0000);
    test_base_vec("srl", 2'b10, 3'b101, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'd4, 32'h0800_0000);
    test_base_vec("srai", 2'b10, 3'b101, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'hF800_0000);
    test_base_vec("sll_shamt5", 2'b10, 3'b001, 1'b0, 1'b0, 1'b1, 32'h0000_0001, 32'h0000_0025, 32'h0000_0020);
  endtask

  task automatic test_compare();
    test_base_vec("sltu", 2'b10, 3'b011, 1'b0, 1'b0, 1'b1, 32'h1, 32'hFFFF_FFFF, 32'h1);
    test_base_vec("slt", 2'b10, 3'b010, 1'b0, 1'b0, 1'b1, 32'h1, 32'hFFFF_FFFF, 32'h0);
  endtask

  task automatic test_arith_logic();
    test_base_vec("aluop_add", 2'b00, 3'b111, 1'b1, 1'b1, 1'b1, 32'd5, 32'd7, 32'd12);
    test_base_vec("aluop_sub", 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4, 32'hFFFF_FFFF);
    test_base_vec("aluop_11_wrap", 2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0);
    test_base_vec("addi_f75", 2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 32'd10, 32'd3, 32'd13);
    test_base_vec("r_sub", 2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'd10, 32'd3, 32'd7);
    test_base_vec("xor", 2'b10, 3'b100, 1'b0, 1'b0, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    test_base_vec("or", 2'b10, 3'b110, 1'b0, 1'b0, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
    test_base_vec("and", 2'b10, 3'b111, 1'b0, 1'b0, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    test_base_vec("itype_f70_add", 2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 32'd2, 32'd3, 32'd5);
  endtask

  task automatic test_multiply();
    test_md_vec("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    test_md_vec("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    test_md_vec("mul", 3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780);
    test_md_vec("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endtask

  task automatic test_divide();
    test_md_vec("div_by0", 3'b100, 32'd7, 32'd0, 32'hFFFF_FFFF);
    test_md_vec("rem_by0", 3'b110, 32'd7, 32'd0, 32'd7);
    test_md_vec("div_neg_by0", 3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
    test_md_vec("rem_neg_by0", 3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
    test_md_vec("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    test_md_vec("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    test_md_vec("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    test_md_vec("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    test_md_vec("divu", 3'b101, 32'd100, 32'd7, 32'd14);
    test_md_vec("remu", 3'b111, 32'd100, 32'd7, 32'd2);
  endtask

  task automatic test_back_to_back();
    int bad_cycle;
    bad_cycle = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step_cycle();
    out_ready = 1'b0;
    issue(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4);
    alu_op = 2'b01; src_a = 32'd3; src_b = 32'd4; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if ((result !== 32'd7 || out_valid !== 1'b1 || in_ready !== 1'b0) && bad_cycle == 0)
        bad_cycle = c + 1;
      step_cycle();
    end
    tests_run++;
    if (bad_cycle != 0) begin
      fails++;
      $display("FAIL b2b hold: cycle %0d result=%h out_valid=%b in_ready=%b required 7/1/0",
               bad_cycle, result, out_valid, in_ready);
    end
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b release in_ready: got %b required 1", in_ready);
    end
    step_cycle();
    in_valid = 1'b0;
    tests_run++;
    if (result !== 32'hFFFF_FFFF || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL b2b sub result: got %h valid=%b required ffffffff valid=1", result, out_valid);
    end
    $display("[TB] b2b add(3,4) held, sub(3,4) -> %h", result);
  endtask

  task automatic test_reset_mid_calc();
    int rose;
    rose = 0;
    out_ready = 1'b1;
    issue(2'b10, 3'b101, 1'b0, 1'b1, 1'b1, 32'd100, 32'd7);
    repeat (9) step_cycle();
    tests_run++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid busy before reset: got %b required 1", busy);
    end
    rst = 1'b1;
    step_cycle();
    rst = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || result !== 32'h0) begin
      fails++;
      $display("FAIL rst_mid state: in_ready=%b busy=%b out_valid=%b result=%h required 1/0/0/0",
               in_ready, busy, out_valid, result);
    end
    for (int c = 0; c < 40; c++) begin
      if (out_valid !== 1'b0) rose = 1;
      step_cycle();
    end
    tests_run++;
    if (rose != 0) begin
      fails++;
      $display("FAIL rst_mid discard: out_valid=1 required 0 after reset");
    end
    test_base_vec("add_after_rst", 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd2);
  endtask

  initial begin
    test_reset();
    test_shift();
    test_compare();
    test_arith_logic();
    test_multiply();
    test_divide();
    test_back_to_back();
    test_reset_mid_calc();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "timeout");
  end

endmodule
